// File: rtl/tetris_pkg.sv
// Shared constants for the tetris playfield Avalon-MM slave: grid geometry,
// register map and STATUS bit positions.
package tetris_pkg;
  localparam int GRID_W     = 10;
  localparam int GRID_H     = 20;
  localparam int GRID_BITS  = GRID_W * GRID_H;
  localparam int SNAP_WORDS = (GRID_BITS + 31) / 32;

  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_SNAP0  = 5'd1;
  localparam logic [4:0] ADDR_SNAP6  = 5'd7;
  localparam logic [4:0] ADDR_LINES  = 5'd8;
  localparam logic [4:0] ADDR_CMD    = 5'd9;

  localparam int ST_GAME_OVER  = 0;
  localparam int ST_SNAP_VALID = 1;
  localparam int ST_IRQ_EN     = 2;
  localparam int ST_PENDING    = 3;
  localparam int ST_LINES_LSB  = 16;

  typedef logic [2:0] snap_idx_t;
endpackage

// File: rtl/tetris_grid_avs_if.sv
// Avalon-MM slave bus used by the Nios to reach the playfield registers.
interface tetris_grid_avs_if;
  logic [4:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/tetris_event_ctr.sv
// Game-event bookkeeping: game_over edge detect, saturating cleared-row
// counter and the sticky interrupt-pending flag.
module tetris_event_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             row_cleared,
  input  logic             game_over,
  input  logic             lines_clr,
  input  logic             pend_clr,
  output logic [CNT_W-1:0] count,
  output logic             pending
);
  logic game_over_q;
  logic go_rise;

  assign go_rise = game_over & ~game_over_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      game_over_q <= 1'b0;
      count       <= '0;
      pending     <= 1'b0;
    end else begin
      game_over_q <= game_over;
      // A clear that coincides with a new row leaves that row counted.
      if (lines_clr)
        count <= row_cleared ? CNT_W'(1) : '0;
      else if (row_cleared && count != {CNT_W{1'b1}})
        count <= count + CNT_W'(1);
      // New events win over a software acknowledge in the same cycle.
      if (row_cleared || go_rise)
        pending <= 1'b1;
      else if (pend_clr)
        pending <= 1'b0;
    end
  end
endmodule

// File: rtl/tetris_grid_avs.sv
// Avalon-MM window onto the tetris playfield: snapshot capture, STATUS,
// lines counter and maskable game-event interrupt.
module tetris_grid_avs
  import tetris_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [GRID_BITS-1:0] grid_state,
  input  logic                 row_cleared,
  input  logic                 game_over,
  tetris_grid_avs_if.slave     avs,
  output logic                 irq
);
  localparam int PAD_BITS = SNAP_WORDS * 32;

  logic [GRID_BITS-1:0] snapshot;
  logic [PAD_BITS-1:0]  snap_pad;
  logic                 snap_valid;
  logic                 irq_en;
  logic                 pending;
  logic [CNT_W-1:0]     count;
  logic                 wr_status, wr_lines, capture;
  snap_idx_t            snap_idx;
  logic [31:0]          rdata;

  assign wr_status = avs.write && avs.address == ADDR_STATUS;
  assign wr_lines  = avs.write && avs.address == ADDR_LINES;
  assign capture   = avs.write && avs.address == ADDR_CMD && avs.writedata[0];
  assign snap_pad  = {{(PAD_BITS-GRID_BITS){1'b0}}, snapshot};
  assign snap_idx  = avs.address[2:0] - 3'd1;

  tetris_event_ctr #(.CNT_W(CNT_W)) u_evt (
    .clk        (clk),
    .reset_n    (reset_n),
    .row_cleared(row_cleared),
    .game_over  (game_over),
    .lines_clr  (wr_lines),
    .pend_clr   (wr_status && avs.writedata[ST_PENDING]),
    .count      (count),
    .pending    (pending)
  );

  always_comb begin
    rdata = '0;
    if (avs.address == ADDR_STATUS) begin
      rdata[ST_GAME_OVER]          = game_over;
      rdata[ST_SNAP_VALID]         = snap_valid;
      rdata[ST_IRQ_EN]             = irq_en;
      rdata[ST_PENDING]            = pending;
      rdata[ST_LINES_LSB +: CNT_W] = count;
    end else if (avs.address >= ADDR_SNAP0 && avs.address <= ADDR_SNAP6) begin
      rdata = snap_pad[32*snap_idx +: 32];
    end else if (avs.address == ADDR_LINES) begin
      rdata[CNT_W-1:0] = count;
    end
  end

  // Read data is sampled from pre-edge state, so a same-cycle write or
  // capture is never visible to the read that accompanies it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
      snapshot     <= '0;
      snap_valid   <= 1'b0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (avs.read) avs.readdata <= rdata;
      if (capture) begin
        snapshot   <= grid_state;
        snap_valid <= 1'b1;
      end
      if (wr_status) irq_en <= avs.writedata[ST_IRQ_EN];
      irq <= irq_en & pending;
    end
  end
endmodule

// File: tb/tb_tetris_grid_avs.sv
// Directed bench for tetris_grid_avs; read expectations go through a scoreboard queue.
module tb_tetris_grid_avs;
  import tetris_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [GRID_BITS-1:0] grid_state;
  logic                 row_cleared;
  logic                 game_over;
  logic                 irq;
  int                   checks = 0;
  int                   failures = 0;
  logic [31:0]          exp_q[$];
  string                tag_q[$];

  tetris_grid_avs_if avs();

  tetris_grid_avs #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .grid_state (grid_state),
    .row_cleared(row_cleared),
    .game_over  (game_over),
    .avs        (avs),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every step starts and ends on a falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
    avs.address = a;
    avs.read    = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick();
    avs.read = 1'b0;
    chk(tag_q.pop_front(), avs.readdata, exp_q.pop_front());
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs.address   = a;
    avs.writedata = d;
    avs.write     = 1'b1;
    tick();
    avs.write = 1'b0;
  endtask

  task automatic rw(input logic [4:0] a, input logic [31:0] d, input logic [31:0] e,
                    input string tag);
    avs.writedata = d;
    avs.write     = 1'b1;
    rd(a, e, tag);
    avs.write = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    grid_state    = '0;
    row_cleared   = 1'b0;
    game_over     = 1'b0;
    avs.address   = '0;
    avs.read      = 1'b0;
    avs.write     = 1'b0;
    avs.writedata = '0;

    // 1. reset behaviour and full address sweep
    tick();
    avs.read = 1'b1;
    tick();
    avs.read = 1'b0;
    chk("rd_in_reset", avs.readdata, 32'h0);
    chk("irq_in_reset", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) rd(5'(a), 32'h0, $sformatf("reset_addr%0d", a));
    chk("irq_after_reset", {31'b0, irq}, 32'h0);

    // 2. snapshot capture
    grid_state[0]   = 1'b1;
    grid_state[199] = 1'b1;
    wr(ADDR_CMD, 32'h1);
    grid_state = '1;
    rd(ADDR_SNAP0, 32'h0000_0001, "snap0");
    rd(5'd2, 32'h0, "snap1");
    rd(ADDR_SNAP6, 32'h0000_0080, "snap6");
    rd(ADDR_STATUS, 32'h0000_0002, "status_snapvalid");

    // 3. snapshot holds; RO/unmapped writes ignored; CMD bit0=0 does nothing
    wr(ADDR_SNAP0, 32'hDEAD_BEEF);
    wr(5'd20, 32'hFFFF_FFFF);
    wr(ADDR_CMD, 32'h2);
    rd(ADDR_SNAP0, 32'h0000_0001, "snap0_hold");
    rd(ADDR_SNAP6, 32'h0000_0080, "snap6_hold");
    rw(ADDR_CMD, 32'h1, 32'h0, "cmd_rw_reads0");
    rd(ADDR_SNAP0, 32'hFFFF_FFFF, "snap0_new");
    rd(ADDR_SNAP6, 32'h0000_00FF, "snap6_new");

    // 4. lines counter
    for (int i = 0; i < 3; i++) begin
      row_cleared = 1'b1; tick(); row_cleared = 1'b0; tick();
    end
    rd(ADDR_LINES, 32'h3, "lines3");
    rd(ADDR_STATUS, 32'h0003_000A, "status_lines3");
    row_cleared = 1'b1; wr(ADDR_LINES, 32'h0); row_cleared = 1'b0;
    rd(ADDR_LINES, 32'h1, "lines_clr_pulse");
    wr(ADDR_LINES, 32'h0);
    rd(ADDR_LINES, 32'h0, "lines_clr");
    row_cleared = 1'b1;
    repeat (65540) tick();
    row_cleared = 1'b0;
    rd(ADDR_LINES, 32'h0000_FFFF, "lines_sat");
    row_cleared = 1'b1; wr(ADDR_LINES, 32'h0); row_cleared = 1'b0;
    rd(ADDR_LINES, 32'h1, "lines_sat_clr_pulse");
    wr(ADDR_LINES, 32'h0);

    // 5. irq: enable + ack, game_over edge, W1C, W1C vs event
    wr(ADDR_STATUS, 32'hC);
    tick();
    chk("irq_acked", {31'b0, irq}, 32'h0);
    game_over = 1'b1;
    tick();
    chk("irq_lag", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_go_rise", {31'b0, irq}, 32'h1);
    rd(ADDR_STATUS, 32'h0000_000F, "status_go");
    wr(ADDR_STATUS, 32'hC);
    chk("irq_w1c_lag", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_w1c", {31'b0, irq}, 32'h0);
    row_cleared = 1'b1; tick(); row_cleared = 1'b0;
    tick();
    chk("irq_row", {31'b0, irq}, 32'h1);
    row_cleared = 1'b1; wr(ADDR_STATUS, 32'hC); row_cleared = 1'b0;
    tick();
    chk("irq_w1c_vs_event", {31'b0, irq}, 32'h1);

    // 6. read+write together, then reset mid-read with game_over still high
    rw(ADDR_STATUS, 32'h8, 32'h0002_000F, "status_rw_prewrite");
    rd(ADDR_STATUS, 32'h0002_0003, "status_postwrite");
    tick();
    chk("irq_disabled", {31'b0, irq}, 32'h0);
    avs.address = ADDR_STATUS;
    avs.read    = 1'b1;
    reset_n     = 1'b0;
    tick();
    avs.read = 1'b0;
    chk("rd_discarded_by_reset", avs.readdata, 32'h0);
    reset_n = 1'b1;
    tick();
    rd(ADDR_STATUS, 32'h0000_0009, "status_go_at_release");
    rd(ADDR_LINES, 32'h0, "lines_after_reset");
    rd(ADDR_SNAP0, 32'h0, "snap0_after_reset");
    rd(ADDR_SNAP6, 32'h0, "snap6_after_reset");
    chk("irq_after_reset2", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
